// File: rtl/zinde_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zinde_pkg
// Brief    : Shared ZindeRV8 constants, loader state encoding and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package zinde_pkg;

    localparam int ZRV8_ADDR_W = 8;
    localparam int ZRV8_DATA_W = 8;

    localparam logic [ZRV8_ADDR_W-1:0] ZRV8_BASE_ADDR = 8'h10;
    localparam logic [ZRV8_DATA_W-1:0] ZRV8_END_MARK  = 8'hFF;

    localparam logic [ZRV8_DATA_W-1:0] ZRV8_OP_BRK = 8'h0F;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_LOAD  = 3'd1,
        LD_PATCH = 3'd2,
        LD_DONE  = 3'd3,
        LD_ERROR = 3'd4
    } ld_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zinde_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : zinde_prog_loader
// Brief    : Streams a program into ZindeRV8 RAM, then hands RAM to the CPU.
//            Define ZRV8_LOADER_PATCH_EN to add a one-byte poke after loading.
// Revision : 1.0 - initial release
// ============================================================================
module zinde_prog_loader
    import zinde_pkg::*;
#(
    parameter logic [ZRV8_ADDR_W-1:0] BASE_ADDR  = ZRV8_BASE_ADDR,
    parameter logic [ZRV8_DATA_W-1:0] END_MARK   = ZRV8_END_MARK,
    parameter logic [ZRV8_ADDR_W-1:0] PATCH_ADDR = 8'h50,
    parameter logic [ZRV8_DATA_W-1:0] PATCH_DATA = 8'h09
) (
    input  logic                   clkn,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   s_valid,
    input  logic [ZRV8_DATA_W-1:0] s_data,
    output logic                   s_ready,
    output logic                   mem_sel,
    output logic                   mem_we,
    output logic [ZRV8_ADDR_W-1:0] mem_adr,
    output logic [ZRV8_DATA_W-1:0] mem_data,
    output logic                   cpu_run,
    output logic                   busy,
    output logic                   err_ovf,
    output logic [7:0]             byte_cnt
);

    ld_state_e              state_q, state_d;
    logic                   sel_q, sel_d;
    logic                   run_q, run_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             cnt_q, cnt_d;
    // Extra MSB flags that the pointer has wrapped past the top of RAM.
    logic [ZRV8_ADDR_W:0]   ptr_q, ptr_d;
    logic                   we_q, we_d;
    logic [ZRV8_ADDR_W-1:0] adr_q, adr_d;
    logic [ZRV8_DATA_W-1:0] dat_q, dat_d;

`ifndef ZRV8_LOADER_PATCH_EN
    logic w_unused_patch;
    assign w_unused_patch = ^{PATCH_ADDR, PATCH_DATA};
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        run_d   = run_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        adr_d   = adr_q;
        dat_d   = dat_q;
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (start) begin
                    state_d = LD_LOAD;
                    sel_d   = 1'b1;
                    run_d   = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_d   = 8'd0;
                    ptr_d   = {1'b0, BASE_ADDR};
                end
            end
            LD_LOAD: begin
                if (s_valid) begin
                    if (s_data == END_MARK) begin
`ifdef ZRV8_LOADER_PATCH_EN
                        state_d = LD_PATCH;
                        we_d    = 1'b1;
                        adr_d   = PATCH_ADDR;
                        dat_d   = PATCH_DATA;
`else
                        state_d = LD_DONE;
                        sel_d   = 1'b0;
                        run_d   = 1'b1;
`endif
                    end else if (ptr_q[ZRV8_ADDR_W]) begin
                        state_d = LD_ERROR;
                        ovf_d   = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        adr_d   = ptr_q[ZRV8_ADDR_W-1:0];
                        dat_d   = s_data;
                        ptr_d   = ptr_q + 9'd1;
                        cnt_d   = sat_inc8(cnt_q);
                    end
                end
            end
            LD_PATCH: begin
                state_d = LD_DONE;
                sel_d   = 1'b0;
                run_d   = 1'b1;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clkn) begin
        if (rstn) begin
            state_q <= LD_IDLE;
            sel_q   <= 1'b0;
            run_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= 8'd0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            run_q   <= run_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clkn) begin
        if (rstn) begin
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
        end else begin
            we_q  <= we_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
        end
    end

    assign s_ready  = (state_q == LD_LOAD);
    assign busy     = (state_q == LD_LOAD) || (state_q == LD_PATCH);
    assign mem_sel  = sel_q;
    assign mem_we   = we_q;
    assign mem_adr  = adr_q;
    assign mem_data = dat_q;
    assign cpu_run  = run_q;
    assign err_ovf  = ovf_q;
    assign byte_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_zinde_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_zinde_prog_loader
// Brief    : Self-checking bench for zinde_prog_loader (default and FE-based).
// Revision : 1.0 - initial release
// ============================================================================
module tb_zinde_prog_loader;
    import zinde_pkg::*;

`ifdef ZRV8_LOADER_PATCH_EN
    localparam bit PATCH = 1'b1;
`else
    localparam bit PATCH = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    logic       rst, start, s_valid, start2, s_valid2;
    logic [7:0] s_data;

    logic       rdy0, sel0, we0, run0, busy0, ovf0;
    logic [7:0] adr0, dat0, cnt0;
    logic       rdy1, sel1, we1, run1, busy1, ovf1;
    logic [7:0] adr1, dat1, cnt1;

    zinde_prog_loader dut0 (
        .clkn(clk), .rstn(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(rdy0), .mem_sel(sel0), .mem_we(we0), .mem_adr(adr0), .mem_data(dat0),
        .cpu_run(run0), .busy(busy0), .err_ovf(ovf0), .byte_cnt(cnt0)
    );

    zinde_prog_loader #(.BASE_ADDR(8'hFE)) dut1 (
        .clkn(clk), .rstn(rst), .start(start2), .s_valid(s_valid2), .s_data(s_data),
        .s_ready(rdy1), .mem_sel(sel1), .mem_we(we1), .mem_adr(adr1), .mem_data(dat1),
        .cpu_run(run1), .busy(busy1), .err_ovf(ovf1), .byte_cnt(cnt1)
    );

    typedef struct packed {
        logic [7:0]  adr;
        logic [7:0]  dat;
        logic [31:0] cyc;
    } wr_t;

    typedef struct packed {
        logic [63:0] bytes;
        logic [3:0]  n;
        logic        gap;
        logic [7:0]  cnt;
    } vec_t;

    wr_t        sb0[$];
    wr_t        sb1[$];
    logic [7:0] ram0[256];
    logic [7:0] ram1[256];
    logic [8:0] mptr[2];
    logic [7:0] mcnt[2];
    int         total = 0;
    int         bad   = 0;
    vec_t       vt[4];

    task automatic note_fail(input string nm, input logic [31:0] a, input logic [31:0] e);
        bad++;
        $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, e, $time);
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) note_fail(nm, a, e);
    endtask

    task automatic mon_one(input int d, input logic [7:0] adr, input logic [7:0] dat, input logic sel);
        wr_t e;
        if ((d == 0 ? sb0.size() : sb1.size()) == 0) begin
            total++;
            note_fail(d == 0 ? "wr_extra0" : "wr_extra1", {16'd0, adr, dat}, 32'd0);
        end else begin
            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            chk("wr_adr", {24'd0, adr}, {24'd0, e.adr});
            chk("wr_dat", {24'd0, dat}, {24'd0, e.dat});
            chk("wr_cyc", cyc, e.cyc);
            chk("wr_sel", {31'd0, sel}, 32'd1);
        end
        if (d == 0) ram0[adr] = dat; else ram1[adr] = dat;
    endtask

    task automatic push(input int d, input logic [7:0] a, input logic [7:0] b);
        wr_t e;
        e.adr = a;
        e.dat = b;
        e.cyc = cyc + 32'd1;
        if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    endtask

    // Reference model: called at the negedge preceding the accepting edge.
    task automatic model_accept(input int d, input logic [7:0] b);
        if (b == ZRV8_END_MARK) begin
            if (PATCH) push(d, 8'h50, 8'h09);
        end else if (!mptr[d][8]) begin
            push(d, mptr[d][7:0], b);
            mptr[d] = mptr[d] + 9'd1;
            mcnt[d] = mcnt[d] + 8'd1;
        end
    endtask

    task automatic pulse(input int d);
        if (d == 0) start = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic do_start(input int d);
        mptr[d] = (d == 0) ? 9'h010 : 9'h0FE;
        mcnt[d] = 8'd0;
        pulse(d);
    endtask

    task automatic send(input int d, input logic [7:0] b, input int gap);
        bit acc = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        if (d == 0) s_valid = 1'b1; else s_valid2 = 1'b1;
        s_data = b;
        for (int i = 0; i < 16 && !acc; i++) begin
            @(negedge clk);
            if ((d == 0) ? rdy0 : rdy1) begin
                acc = 1'b1;
                model_accept(d, b);
                @(posedge clk); #1;
            end
        end
        s_valid  = 1'b0;
        s_valid2 = 1'b0;
        if (!acc) begin
            total++;
            note_fail("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_done(input int d, input logic [7:0] ecnt);
        bit ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if ((d == 0) ? run0 : run1) ok = 1'b1;
        end
        chk("done_run", {31'd0, ok}, 32'd1);
        chk("done_cnt",  {24'd0, (d == 0) ? cnt0 : cnt1}, {24'd0, ecnt});
        chk("done_mcnt", {24'd0, mcnt[d]}, {24'd0, ecnt});
        chk("done_sel",  {31'd0, (d == 0) ? sel0 : sel1}, 32'd0);
        chk("done_busy", {31'd0, (d == 0) ? busy0 : busy1}, 32'd0);
        chk("done_ovf",  {31'd0, (d == 0) ? ovf0 : ovf1}, 32'd0);
        chk("done_rdy",  {31'd0, (d == 0) ? rdy0 : rdy1}, 32'd0);
        chk("done_sb",   (d == 0) ? sb0.size() : sb1.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic clr_ram;
        for (int a = 0; a < 256; a++) begin
            ram0[a] = 8'h00;
            ram1[a] = 8'h00;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; s_valid = 1'b0; s_valid2 = 1'b0; s_data = 8'h00;
        mptr[0] = 9'h010; mptr[1] = 9'h0FE; mcnt[0] = 8'd0; mcnt[1] = 8'd0;
        clr_ram();
        fork
            forever begin
                @(negedge clk);
                if (we0) mon_one(0, adr0, dat0, sel0);
                if (we1) mon_one(1, adr1, dat1, sel1);
            end
        join_none

        vt[0] = '{bytes: 64'h32_05_46_50_44_60_0F_FF, n: 4'd8, gap: 1'b0, cnt: 8'd7};
        vt[1] = '{bytes: 64'h32_05_46_50_44_60_0F_FF, n: 4'd8, gap: 1'b1, cnt: 8'd7};
        vt[2] = '{bytes: 64'hFF_00_00_00_00_00_00_00, n: 4'd1, gap: 1'b0, cnt: 8'd0};
        vt[3] = '{bytes: 64'h01_02_FF_00_00_00_00_00, n: 4'd3, gap: 1'b1, cnt: 8'd2};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy",  {31'd0, rdy0},  32'd0);
        chk("rst_sel",  {31'd0, sel0},  32'd0);
        chk("rst_we",   {31'd0, we0},   32'd0);
        chk("rst_adr",  {24'd0, adr0},  32'd0);
        chk("rst_dat",  {24'd0, dat0},  32'd0);
        chk("rst_run",  {31'd0, run0},  32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_ovf",  {31'd0, ovf0},  32'd0);
        chk("rst_cnt",  {24'd0, cnt0},  32'd0);
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            clr_ram();
            do_start(0);
            chk("load_busy", {31'd0, busy0}, 32'd1);
            chk("load_sel",  {31'd0, sel0},  32'd1);
            for (int i = 0; i < int'(vt[v].n); i++)
                send(0, vt[v].bytes[63-8*i -: 8], vt[v].gap ? int'($urandom_range(1, 3)) : 0);
            wait_done(0, vt[v].cnt);
            for (int i = 0; i < int'(vt[v].n) - 1; i++)
                chk("ram_img", {24'd0, ram0[16+i]}, {24'd0, vt[v].bytes[63-8*i -: 8]});
        end

        // Overflow with BASE_ADDR=FE: FE and FF written, third byte rejected.
        clr_ram();
        do_start(1);
        send(1, 8'hAA, 0);
        send(1, 8'hBB, 0);
        send(1, 8'hCC, 0);
        @(negedge clk);
        chk("ovf_flag", {31'd0, ovf1},  32'd1);
        chk("ovf_run",  {31'd0, run1},  32'd0);
        chk("ovf_sel",  {31'd0, sel1},  32'd1);
        chk("ovf_rdy",  {31'd0, rdy1},  32'd0);
        chk("ovf_busy", {31'd0, busy1}, 32'd0);
        chk("ovf_cnt",  {24'd0, cnt1},  32'd2);
        chk("ovf_sb",   sb1.size(),     32'd0);
        chk("ovf_ramFE", {24'd0, ram1[8'hFE]}, 32'h0AA);
        chk("ovf_ramFF", {24'd0, ram1[8'hFF]}, 32'h0BB);
        @(posedge clk); #1;
        do_start(1);
        @(negedge clk);
        chk("err_restart_ovf",  {31'd0, ovf1},  32'd0);
        chk("err_restart_busy", {31'd0, busy1}, 32'd1);
        @(posedge clk); #1;
        send(1, ZRV8_END_MARK, 0);
        wait_done(1, 8'd0);

        // Reset mid-load: third write already in flight, fourth byte dropped.
        clr_ram();
        do_start(0);
        send(0, 8'hA1, 0);
        send(0, 8'hA2, 0);
        send(0, 8'hA3, 0);
        rst = 1'b1; s_valid = 1'b1; s_data = 8'hA4;
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("mrst_we",   {31'd0, we0},   32'd0);
        chk("mrst_sel",  {31'd0, sel0},  32'd0);
        chk("mrst_rdy",  {31'd0, rdy0},  32'd0);
        chk("mrst_busy", {31'd0, busy0}, 32'd0);
        chk("mrst_adr",  {24'd0, adr0},  32'd0);
        chk("mrst_dat",  {24'd0, dat0},  32'd0);
        chk("mrst_cnt",  {24'd0, cnt0},  32'd0);
        chk("mrst_sb",   sb0.size(),     32'd0);
        chk("mrst_ram",  {24'd0, ram0[8'h12]}, 32'h0A3);
        @(posedge clk); #1;
        do_start(0);
        send(0, 8'hB1, 0);
        send(0, ZRV8_END_MARK, 0);
        wait_done(0, 8'd1);
        chk("reload_ram", {24'd0, ram0[8'h10]}, 32'h0B1);

        // start during LOAD is ignored; start in DONE restarts cleanly.
        clr_ram();
        do_start(0);
        send(0, 8'h11, 0);
        send(0, 8'h22, 0);
        pulse(0);
        send(0, 8'h33, 0);
        send(0, ZRV8_END_MARK, 0);
        wait_done(0, 8'd3);
        chk("ign_ram12", {24'd0, ram0[8'h12]}, 32'h033);
        do_start(0);
        @(negedge clk);
        chk("rest_run",  {31'd0, run0},  32'd0);
        chk("rest_cnt",  {24'd0, cnt0},  32'd0);
        chk("rest_ovf",  {31'd0, ovf0},  32'd0);
        chk("rest_sel",  {31'd0, sel0},  32'd1);
        chk("rest_busy", {31'd0, busy0}, 32'd1);
        chk("rest_rdy",  {31'd0, rdy0},  32'd1);
        @(posedge clk); #1;
        send(0, 8'h44, 0);
        send(0, ZRV8_END_MARK, 0);
        wait_done(0, 8'd1);
        chk("rest_ram10", {24'd0, ram0[8'h10]}, 32'h044);

        repeat (3) @(posedge clk);
        chk("end_sb0", sb0.size(), 32'd0);
        chk("end_sb1", sb1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
